// File: rtl/scramble_copy_engine.sv
// ROM-to-RAM copy engine that bit-interleaves (or de-interleaves) every word on the way through.
// Define SCRAMBLE_VERIFY_EN to add a read-back verify pass after the copy.
module scramble_copy_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              zero_skip,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_cs_n,
    output logic              rom_oe,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs_n,
    output logic              ram_oe,
    output logic              ram_ws_n,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned       Half    = DATA_W / 2;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    typedef enum logic [3:0] {
        StIdle,
        StRomAddr,
        StRomCap,
        StWrSetup,
        StWrPulse,
        StWrHold,
`ifdef SCRAMBLE_VERIFY_EN
        StVAddr,
        StVCmp,
`endif
        StDone
    } state_e;

    // desc=0: low half goes to odd bits from the top down, high half to even bits from the bottom up.
    function automatic logic [DATA_W-1:0] transform(input logic [DATA_W-1:0] din,
                                                    input logic              desc);
        logic [DATA_W-1:0] dout;
        dout = '0;
        for (int k = 0; k < Half; k++) begin
            if (!desc) begin
                dout[DATA_W-1-2*k] = din[k];
                dout[2*k]          = din[Half+k];
            end else begin
                dout[k]      = din[DATA_W-1-2*k];
                dout[Half+k] = din[2*k];
            end
        end
        return dout;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                mode_q, mode_d;
    logic                skip_q, skip_d;
    logic                last_word;
    logic                skip_word;
    state_e              after_copy;

    assign last_word = (index_q == LastIdx);
    assign skip_word = skip_q && (rom_data == '0);

`ifdef SCRAMBLE_VERIFY_EN
    logic              verr_q, verr_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    assign after_copy = last_word ? StVAddr : StRomAddr;
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign after_copy   = last_word ? StDone : StRomAddr;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StRomAddr;
            StRomAddr: state_d = StRomCap;
            StRomCap:  state_d = skip_word ? after_copy : StWrSetup;
            StWrSetup: state_d = StWrPulse;
            StWrPulse: state_d = StWrHold;
            StWrHold:  state_d = after_copy;
`ifdef SCRAMBLE_VERIFY_EN
            StVAddr:   state_d = StVCmp;
            StVCmp:    state_d = last_word ? StDone : StVAddr;
`endif
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        index_d = index_q;
        word_d  = word_q;
        count_d = count_q;
        mode_d  = mode_q;
        skip_d  = skip_q;
`ifdef SCRAMBLE_VERIFY_EN
        verr_d  = verr_q;
        eaddr_d = eaddr_q;
`endif
        if (state_q == StIdle && start) begin
            index_d = '0;
            count_d = '0;
            mode_d  = mode;
            skip_d  = zero_skip;
`ifdef SCRAMBLE_VERIFY_EN
            verr_d  = 1'b0;
            eaddr_d = '0;
`endif
        end
        if (state_q == StRomCap) begin
            word_d = rom_data;
        end
        if (state_q == StWrPulse) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end
        // Wrap to 0 after the last word so a verify pass starts at address 0.
        if ((state_q == StRomCap && skip_word) || state_q == StWrHold) begin
            index_d = last_word ? '0 : index_q + ADDR_W'(1);
        end
`ifdef SCRAMBLE_VERIFY_EN
        if (state_q == StVCmp) begin
            index_d = last_word ? '0 : index_q + ADDR_W'(1);
            if (!skip_word && transform(rom_data, mode_q) != ram_rdata) begin
                verr_d = 1'b1;
                if (!verr_q) eaddr_d = index_q;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            word_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            skip_q  <= 1'b0;
`ifdef SCRAMBLE_VERIFY_EN
            verr_q  <= 1'b0;
            eaddr_q <= '0;
`endif
        end else begin
            index_q <= index_d;
            word_q  <= word_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            skip_q  <= skip_d;
`ifdef SCRAMBLE_VERIFY_EN
            verr_q  <= verr_d;
            eaddr_q <= eaddr_d;
`endif
        end
    end

    // Outputs are decoded from state so an asynchronous reset drops the strobes immediately.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        rom_addr  = '0;
        rom_cs_n  = 1'b1;
        rom_oe    = 1'b0;
        ram_addr  = '0;
        ram_cs_n  = 1'b1;
        ram_oe    = 1'b1;
        ram_ws_n  = 1'b1;
        ram_wdata = '0;
        unique case (state_q)
            StIdle: ;
            StRomAddr, StRomCap: begin
                busy     = 1'b1;
                rom_addr = index_q;
                rom_cs_n = 1'b0;
                rom_oe   = 1'b1;
            end
            StWrSetup, StWrPulse, StWrHold: begin
                busy      = 1'b1;
                ram_addr  = index_q;
                ram_cs_n  = 1'b0;
                ram_oe    = 1'b0;
                ram_wdata = transform(word_q, mode_q);
                ram_ws_n  = (state_q != StWrPulse);
            end
`ifdef SCRAMBLE_VERIFY_EN
            StVAddr, StVCmp: begin
                busy     = 1'b1;
                rom_addr = index_q;
                rom_cs_n = 1'b0;
                rom_oe   = 1'b1;
                ram_addr = index_q;
                ram_cs_n = 1'b0;
            end
`endif
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign words_written = count_q;
`ifdef SCRAMBLE_VERIFY_EN
    assign verify_err = verr_q;
    assign err_addr   = eaddr_q;
`else
    assign verify_err = 1'b0;
    assign err_addr   = '0;
`endif

endmodule
